// File: rtl/aes_pkg.sv
// Shared AES definitions: key-length codes, round counts, decipher FSM states
// and the GF(2^8) helpers behind InvMixColumns.
package aes_pkg;

  localparam logic AES_128_BIT_KEY = 1'b0;
  localparam logic AES_256_BIT_KEY = 1'b1;

  localparam logic [3:0] AES_128_NUM_ROUNDS = 4'd10;
  localparam logic [3:0] AES_256_NUM_ROUNDS = 4'd14;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StInit  = 2'd1,
    StMain  = 2'd2,
    StFinal = 2'd3
  } dec_state_e;

  function automatic logic [3:0] num_rounds(input logic keylen);
    return (keylen == AES_128_BIT_KEY) ? AES_128_NUM_ROUNDS : AES_256_NUM_ROUNDS;
  endfunction

  // Multiply by x modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gm2(input logic [7:0] op);
    return {op[6:0], 1'b0} ^ (8'h1b & {8{op[7]}});
  endfunction

  function automatic logic [7:0] gm4(input logic [7:0] op);
    return gm2(gm2(op));
  endfunction

  function automatic logic [7:0] gm8(input logic [7:0] op);
    return gm2(gm4(op));
  endfunction

  function automatic logic [7:0] gm09(input logic [7:0] op);
    return gm8(op) ^ op;
  endfunction

  function automatic logic [7:0] gm11(input logic [7:0] op);
    return gm8(op) ^ gm2(op) ^ op;
  endfunction

  function automatic logic [7:0] gm13(input logic [7:0] op);
    return gm8(op) ^ gm4(op) ^ op;
  endfunction

  function automatic logic [7:0] gm14(input logic [7:0] op);
    return gm8(op) ^ gm4(op) ^ gm2(op);
  endfunction

  function automatic logic [31:0] inv_mixw(input logic [31:0] w);
    logic [7:0] b0, b1, b2, b3;
    logic [7:0] mb0, mb1, mb2, mb3;
    b0  = w[31:24];
    b1  = w[23:16];
    b2  = w[15:8];
    b3  = w[7:0];
    mb0 = gm14(b0) ^ gm11(b1) ^ gm13(b2) ^ gm09(b3);
    mb1 = gm09(b0) ^ gm14(b1) ^ gm11(b2) ^ gm13(b3);
    mb2 = gm13(b0) ^ gm09(b1) ^ gm14(b2) ^ gm11(b3);
    mb3 = gm11(b0) ^ gm13(b1) ^ gm09(b2) ^ gm14(b3);
    return {mb0, mb1, mb2, mb3};
  endfunction

endpackage

// File: rtl/aes_decipher_block_if.sv
// Data and key-memory signals between the core and the inverse cipher.
interface aes_decipher_block_if;

  logic         next;
  logic         keylen;
  logic [3:0]   round;
  logic [127:0] round_key;
  logic [127:0] block;
  logic [127:0] new_block;
  logic         ready;

  modport master (
    output next, keylen, round_key, block,
    input  round, new_block, ready
  );

  modport slave (
    input  next, keylen, round_key, block,
    output round, new_block, ready
  );

endinterface

// File: rtl/aes_inv_sbox.sv
// Four parallel AES inverse S-box lookups on one 32-bit word.
module aes_inv_sbox (
  input  logic [31:0] sboxw,
  output logic [31:0] new_sboxw
);

  // Element 0 sits in the most significant byte of the first row.
  localparam logic [0:255][7:0] InvSbox = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  assign new_sboxw = {InvSbox[sboxw[31:24]], InvSbox[sboxw[23:16]],
                      InvSbox[sboxw[15:8]],  InvSbox[sboxw[7:0]]};

endmodule

// File: rtl/aes_decipher_block.sv
// Iterative AES-128/256 inverse cipher, one full round per clock, round keys read descending.
// Optional AES_DECIPHER_ZEROIZE_EN adds a zeroize input that clears state and returns to idle.
module aes_decipher_block
  import aes_pkg::*;
(
  input logic clk,
  input logic reset,
`ifdef AES_DECIPHER_ZEROIZE_EN
  input logic zeroize,
`endif
  aes_decipher_block_if.slave dec
);

  // State is column-major: column c occupies data[127-32c -: 32], row r is byte r of it.
  function automatic logic [127:0] inv_shiftrows(input logic [127:0] data);
    logic [31:0] w0, w1, w2, w3;
    w0 = data[127:96];
    w1 = data[95:64];
    w2 = data[63:32];
    w3 = data[31:0];
    return {w0[31:24], w3[23:16], w2[15:8], w1[7:0],
            w1[31:24], w0[23:16], w3[15:8], w2[7:0],
            w2[31:24], w1[23:16], w0[15:8], w3[7:0],
            w3[31:24], w2[23:16], w1[15:8], w0[7:0]};
  endfunction

  function automatic logic [127:0] inv_mixcolumns(input logic [127:0] data);
    return {inv_mixw(data[127:96]), inv_mixw(data[95:64]),
            inv_mixw(data[63:32]),  inv_mixw(data[31:0])};
  endfunction

  dec_state_e   state_q, state_d;
  logic [127:0] block_reg_q, block_reg_d;
  logic [3:0]   round_ctr_q, round_ctr_d;
  logic         keylen_reg_q, keylen_reg_d;
  logic         ready_q, ready_d;

  logic [127:0] shifted, subbed, final_result, main_result;
  logic         zero_req;

`ifdef AES_DECIPHER_ZEROIZE_EN
  assign zero_req = zeroize;
`else
  assign zero_req = 1'b0;
`endif

  // ShiftRows only permutes bytes, so substituting after it is equivalent.
  assign shifted = inv_shiftrows(block_reg_q);

  for (genvar i = 0; i < 4; i++) begin : g_inv_sbox
    aes_inv_sbox u_inv_sbox (
      .sboxw     (shifted[127-32*i -: 32]),
      .new_sboxw (subbed[127-32*i -: 32])
    );
  end

  assign final_result = subbed ^ dec.round_key;
  assign main_result  = inv_mixcolumns(final_result);

  assign dec.new_block = block_reg_q;
  assign dec.ready     = ready_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      block_reg_q  <= '0;
      round_ctr_q  <= '0;
      keylen_reg_q <= AES_128_BIT_KEY;
      ready_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      block_reg_q  <= block_reg_d;
      round_ctr_q  <= round_ctr_d;
      keylen_reg_q <= keylen_reg_d;
      ready_q      <= ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (zero_req) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:  if (dec.next) state_d = StInit;
        StInit:  state_d = StMain;
        StMain:  if (round_ctr_q == 4'd1) state_d = StFinal;
        StFinal: state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    block_reg_d  = block_reg_q;
    round_ctr_d  = round_ctr_q;
    keylen_reg_d = keylen_reg_q;
    ready_d      = ready_q;
    dec.round    = 4'd0;

    unique case (state_q)
      StIdle: begin
        if (dec.next) begin
          block_reg_d  = dec.block;
          keylen_reg_d = dec.keylen;
          ready_d      = 1'b0;
          round_ctr_d  = num_rounds(dec.keylen);
        end
      end
      StInit: begin
        dec.round   = num_rounds(keylen_reg_q);
        block_reg_d = block_reg_q ^ dec.round_key;
        round_ctr_d = num_rounds(keylen_reg_q) - 4'd1;
      end
      StMain: begin
        dec.round   = round_ctr_q;
        block_reg_d = main_result;
        if (round_ctr_q != 4'd0) round_ctr_d = round_ctr_q - 4'd1;
      end
      StFinal: begin
        block_reg_d = final_result;
        ready_d     = 1'b1;
      end
      default: ;
    endcase

    // Zeroize wins over an accepted start; nothing from that cycle is kept.
    if (zero_req) begin
      block_reg_d  = '0;
      round_ctr_d  = '0;
      keylen_reg_d = keylen_reg_q;
      ready_d      = 1'b1;
    end
  end

endmodule

// File: tb/tb_aes_decipher_block.sv
// Bench for aes_decipher_block: FIPS-197 vectors, control corner cases and random
// keys/blocks checked against a byte-level inverse-cipher model with its own key schedule.
module tb_aes_decipher_block;
  import aes_pkg::*;

  localparam logic [255:0] Key128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] Key256 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] Ct128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] Ct256 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] Pt    = 128'h00112233445566778899aabbccddeeff;

  logic clk;
  logic reset;
`ifdef AES_DECIPHER_ZEROIZE_EN
  logic zeroize;
`endif

  aes_decipher_block_if dif ();

  aes_decipher_block dut (
    .clk     (clk),
    .reset   (reset),
`ifdef AES_DECIPHER_ZEROIZE_EN
    .zeroize (zeroize),
`endif
    .dec     (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]   sbox_t  [256];
  logic [7:0]   isbox_t [256];
  logic [127:0] rk_mem  [16];
  int           n_cmp;
  int           n_err;

  // Key memory: combinational read of the current round key.
  assign dif.round_key = rk_mem[dif.round];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box from first principles: multiplicative inverse then affine transform.
  function automatic logic [7:0] sbox_calc(input logic [7:0] a);
    logic [7:0] inv;
    inv = 8'h00;
    for (int i = 1; i < 256; i++) if (gmul(a, 8'(i)) == 8'h01) inv = 8'(i);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
           {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  task automatic expand_key(input logic [255:0] key, input logic kl);
    logic [31:0] w [64];
    logic [31:0] t;
    logic [7:0]  rcon;
    int nk, nr;
    nk   = (kl == AES_256_BIT_KEY) ? 8 : 4;
    nr   = (kl == AES_256_BIT_KEY) ? 14 : 10;
    rcon = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t    = subw({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end else if (nk == 8 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 16; r++) rk_mem[r] = '0;
    for (int r = 0; r <= nr; r++) rk_mem[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] ref_decrypt(input logic [127:0] ct, input logic kl);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] k;
    logic [127:0] res;
    int nr;
    nr = (kl == AES_256_BIT_KEY) ? 14 : 10;
    k  = ct ^ rk_mem[nr];
    for (int i = 0; i < 16; i++) s[i] = k[127-8*i -: 8];
    for (int r = nr - 1; r >= 0; r--) begin
      k = rk_mem[r];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++)
          t[4*c+row] = isbox_t[s[4*((c-row+4)%4)+row]] ^ k[127-8*(4*c+row) -: 8];
      for (int c = 0; c < 4; c++) begin
        if (r == 0) begin
          for (int row = 0; row < 4; row++) s[4*c+row] = t[4*c+row];
        end else begin
          s[4*c]   = gmul(t[4*c], 8'h0e) ^ gmul(t[4*c+1], 8'h0b) ^
                     gmul(t[4*c+2], 8'h0d) ^ gmul(t[4*c+3], 8'h09);
          s[4*c+1] = gmul(t[4*c], 8'h09) ^ gmul(t[4*c+1], 8'h0e) ^
                     gmul(t[4*c+2], 8'h0b) ^ gmul(t[4*c+3], 8'h0d);
          s[4*c+2] = gmul(t[4*c], 8'h0d) ^ gmul(t[4*c+1], 8'h09) ^
                     gmul(t[4*c+2], 8'h0e) ^ gmul(t[4*c+3], 8'h0b);
          s[4*c+3] = gmul(t[4*c], 8'h0b) ^ gmul(t[4*c+1], 8'h0d) ^
                     gmul(t[4*c+2], 8'h09) ^ gmul(t[4*c+3], 8'h0e);
        end
      end
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // Expected round-index trace Nr, Nr-1, ..., 0 packed four bits per cycle.
  function automatic logic [63:0] exp_seq(input logic kl);
    logic [63:0] s;
    s = '0;
    for (int r = (kl == AES_256_BIT_KEY) ? 14 : 10; r >= 0; r--) s = {s[59:0], 4'(r)};
    return s;
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic start(input logic kl, input logic [127:0] blk);
    @(negedge clk);
    dif.next   = 1'b1;
    dif.keylen = kl;
    dif.block  = blk;
  endtask

  // Starts at the accepting edge; lat counts edges including that one until ready is seen.
  task automatic finish_op(input bit hold, input bit disturb, output int lat,
                           output logic [63:0] seq, output logic [127:0] res);
    @(posedge clk);
    lat = 1;
    seq = '0;
    @(negedge clk);
    if (!hold) dif.next = 1'b0;
    while (!dif.ready && lat < 40) begin
      if (disturb && lat == 4) begin
        dif.next   = 1'b1;
        dif.block  = {$urandom, $urandom, $urandom, $urandom};
        dif.keylen = ~dif.keylen;
      end
      if (disturb && lat == 5 && !hold) dif.next = 1'b0;
      seq = {seq[59:0], dif.round};
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    res = dif.new_block;
  endtask

  initial begin
    int           lat;
    int           guard;
    logic [63:0]  seq;
    logic [127:0] res;
    logic [127:0] ct;
    logic [255:0] key;
    logic         kl;

    n_cmp      = 0;
    n_err      = 0;
    reset      = 1'b1;
    dif.next   = 1'b0;
    dif.keylen = AES_128_BIT_KEY;
    dif.block  = '0;
`ifdef AES_DECIPHER_ZEROIZE_EN
    zeroize    = 1'b0;
`endif
    for (int x = 0; x < 256; x++) sbox_t[x] = sbox_calc(8'(x));
    for (int x = 0; x < 256; x++) isbox_t[sbox_t[x]] = 8'(x);
    for (int r = 0; r < 16; r++) rk_mem[r] = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_ready", dif.ready, 1);
    check("rst_new_block", dif.new_block, 0);
    check("rst_round", dif.round, 0);

    // FIPS-197 AES-128
    expand_key(Key128, AES_128_BIT_KEY);
    start(AES_128_BIT_KEY, Ct128);
    finish_op(0, 0, lat, seq, res);
    check("aes128_pt", res, Pt);
    check("aes128_latency", lat, 12);
    check("aes128_rounds", seq, exp_seq(AES_128_BIT_KEY));

    repeat (3) @(negedge clk);
    check("idle_hold_block", dif.new_block, Pt);
    check("idle_hold_ready", dif.ready, 1);
    check("idle_round", dif.round, 0);

    // FIPS-197 AES-256
    expand_key(Key256, AES_256_BIT_KEY);
    start(AES_256_BIT_KEY, Ct256);
    finish_op(0, 0, lat, seq, res);
    check("aes256_pt", res, Pt);
    check("aes256_latency", lat, 16);
    check("aes256_rounds", seq, exp_seq(AES_256_BIT_KEY));

    // Back-to-back with next held; keylen/block disturbed during the first run
    expand_key(Key128, AES_128_BIT_KEY);
    start(AES_128_BIT_KEY, Ct128);
    finish_op(1, 1, lat, seq, res);
    check("b2b_first_pt", res, Pt);
    check("b2b_first_latency", lat, 12);
    check("b2b_ready_hi", dif.ready, 1);
    expand_key(Key256, AES_256_BIT_KEY);
    dif.keylen = AES_256_BIT_KEY;
    dif.block  = Ct256;
    finish_op(0, 0, lat, seq, res);
    check("b2b_second_pt", res, Pt);
    check("b2b_second_latency", lat, 16);
    check("b2b_second_rounds", seq, exp_seq(AES_256_BIT_KEY));

    // Reset in MAIN at round 5
    expand_key(Key128, AES_128_BIT_KEY);
    start(AES_128_BIT_KEY, Ct128);
    @(posedge clk);
    @(negedge clk);
    dif.next = 1'b0;
    guard    = 0;
    while (dif.round != 4'd5 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    check("rst_mid_reached_r5", dif.round, 5);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid_ready", dif.ready, 1);
    check("rst_mid_new_block", dif.new_block, 0);
    check("rst_mid_round", dif.round, 0);
    start(AES_128_BIT_KEY, Ct128);
    finish_op(0, 0, lat, seq, res);
    check("after_rst_pt", res, Pt);

    // next pulse and block/keylen changes mid-run are ignored
    start(AES_128_BIT_KEY, Ct128);
    finish_op(0, 1, lat, seq, res);
    check("disturb_pt", res, Pt);
    check("disturb_latency", lat, 12);
    repeat (2) @(negedge clk);
    check("disturb_no_restart", dif.ready, 1);

    // Random keys, key lengths and ciphertexts against the model
    for (int i = 0; i < 6; i++) begin
      key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      kl  = 1'($urandom_range(0, 1));
      ct  = {$urandom, $urandom, $urandom, $urandom};
      expand_key(key, kl);
      start(kl, ct);
      finish_op(0, 0, lat, seq, res);
      check($sformatf("rand%0d_pt", i), res, ref_decrypt(ct, kl));
      check($sformatf("rand%0d_latency", i), lat, (kl == AES_256_BIT_KEY) ? 16 : 12);
    end

`ifdef AES_DECIPHER_ZEROIZE_EN
    // Zeroize in MAIN with next asserted
    start(kl, ct);
    @(posedge clk);
    repeat (3) @(negedge clk);
    zeroize = 1'b1;
    @(posedge clk);
    @(negedge clk);
    zeroize  = 1'b0;
    dif.next = 1'b0;
    check("zero_ready", dif.ready, 1);
    check("zero_new_block", dif.new_block, 0);
    check("zero_round", dif.round, 0);
    @(negedge clk);
    check("zero_no_start", dif.ready, 1);
    check("zero_stays_clear", dif.new_block, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
